// File: rtl/regs_unloader.sv
// regs_unloader: snapshots four packed complex samples on a load pulse and
// streams them out one per beat over a valid/ready handshake, then pulses
// done for one cycle after the fourth transfer.
//
// Build option: define REGS_UNLOADER_BITREV_EN to emit beats in 2-bit
// bit-reversed order (0,2,1,3) instead of natural order (0,1,2,3).

module regs_unloader #(
   parameter int unsigned fix_bit = 7,
   parameter int unsigned bits    = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                load,
   input  logic [2*bits-1:0]   in0,
   input  logic [2*bits-1:0]   in1,
   input  logic [2*bits-1:0]   in2,
   input  logic [2*bits-1:0]   in3,
   output logic                busy,
   output logic [2*bits-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [1:0]          out_idx,
   output logic                done
);

   // fix_bit only documents the fixed-point format; it never alters the width
   localparam int unsigned SampleW = 2 * bits + 0 * fix_bit;

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e             state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic               done_q, done_d;
   logic               snap_en;
   logic [SampleW-1:0] snap_q [4];
   logic [1:0]         beat_idx;

   // Map the beat counter onto the source register index
`ifdef REGS_UNLOADER_BITREV_EN
   assign beat_idx = {cnt_q[0], cnt_q[1]};
`else
   assign beat_idx = cnt_q;
`endif

   // State, beat counter and done pulse registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Snapshot registers, written only when a load is accepted in IDLE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            snap_q[i] <= '0;
         end
      end else if (snap_en) begin
         snap_q[0] <= in0;
         snap_q[1] <= in1;
         snap_q[2] <= in2;
         snap_q[3] <= in3;
      end
   end

   // Next-state logic: accept load in IDLE, count transfers in SEND
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      snap_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               state_d = StSend;
               cnt_d   = 2'd0;
               snap_en = 1'b1;
            end
         end
         StSend: begin
            // out_valid is 1 throughout SEND, so out_ready alone means transfer
            if (out_ready) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs derive from registered state only; zero while idle
   always_comb begin
      busy      = 1'b0;
      out_valid = 1'b0;
      out_idx   = 2'd0;
      out_data  = '0;
      done      = done_q;
      if (state_q == StSend) begin
         busy      = 1'b1;
         out_valid = 1'b1;
         out_idx   = beat_idx;
         out_data  = snap_q[beat_idx];
      end
   end

endmodule

// File: tb/tb_regs_unloader.sv
// Self-checking bench for regs_unloader: a small cycle model pushes expected
// beats into a scoreboard queue whenever a load is accepted and pops them as
// beats transfer; handshake, stall hold, busy and done are checked every cycle.

module tb_regs_unloader;

   localparam int unsigned Bits = 16;
   localparam int unsigned W    = 2 * Bits;

   logic          clk;
   logic          reset_n;
   logic          load;
   logic [W-1:0]  din [4];
   logic          busy;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_idx;
   logic          done;

   regs_unloader #(
      .fix_bit (7),
      .bits    (Bits)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .in0       (din[0]),
      .in1       (din[1]),
      .in2       (din[2]),
      .in3       (din[3]),
      .busy      (busy),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Scoreboard entries: {idx, data}
   logic [W+1:0] sb [$];

   // Reference model state
   logic         m_send  = 1'b0;
   logic         m_done  = 1'b0;
   int           m_beat  = 0;
   logic         m_stall = 1'b0;
   logic [W-1:0] st_data;
   logic [1:0]   st_idx;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] order(input int k);
      logic [1:0] kk;
      kk = k[1:0];
`ifdef REGS_UNLOADER_BITREV_EN
      return {kk[0], kk[1]};
`else
      return kk;
`endif
   endfunction

   task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
      din[0] = a;
      din[1] = b;
      din[2] = c;
      din[3] = d;
   endtask

   // One clock cycle: inputs are already driven; check, advance model, clock
   task automatic cycle();
      logic         xfer;
      logic [W+1:0] e;
      check("busy", 64'(busy), 64'(m_send));
      check("out_valid", 64'(out_valid), 64'(m_send));
      check("done", 64'(done), 64'(m_done));
      if (m_stall) begin
         check("stall_data", 64'(out_data), 64'(st_data));
         check("stall_idx", 64'(out_idx), 64'(st_idx));
      end
      xfer = m_send && out_ready;
      if (xfer) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 64'(1), 64'(0));
         end else begin
            e = sb.pop_front();
            check("beat_data", 64'(out_data), 64'(e[W-1:0]));
            check("beat_idx", 64'(out_idx), 64'(e[W+1:W]));
         end
      end
      m_stall = m_send && !out_ready;
      st_data = out_data;
      st_idx  = out_idx;
      m_done  = xfer && (m_beat == 3);
      if (!m_send && load) begin
         for (int k = 0; k < 4; k++) begin
            sb.push_back({order(k), din[order(k)]});
         end
         m_send = 1'b1;
         m_beat = 0;
      end else if (xfer) begin
         m_beat++;
         if (m_beat == 4) m_send = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      load      = 1'b0;
      out_ready = 1'b0;
      set_in('0, '0, '0, '0);
      #1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_data", 64'(out_data), 64'(0));
      check("rst_idx", 64'(out_idx), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Plain drain, load honoured in the first cycle after release
      set_in(32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008);
      load = 1'b1; out_ready = 1'b1;
      cycle();
      load = 1'b0;
      repeat (6) cycle();
      check("drain_empty", 64'(sb.size()), 64'(0));

      // Backpressure with ready pattern 1,0,0,1,0,1,1
      load = 1'b1; out_ready = 1'b0;
      cycle();
      load = 1'b0;
      foreach (din[i]) din[i] = 32'hDEAD_0000 + 32'(i); // post-load changes must not leak
      for (int i = 0; i < 7; i++) begin
         out_ready = ((7'b1101001 >> i) & 7'd1) != 0;
         cycle();
      end
      out_ready = 1'b1;
      repeat (2) cycle();
      check("bp_empty", 64'(sb.size()), 64'(0));

      // Load during SEND at beat 1 must be ignored
      set_in(32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004);
      load = 1'b1;
      cycle();
      load = 1'b0;
      cycle();
      set_in(32'hFFFF_0000, 32'hFFFF_0001, 32'hFFFF_0002, 32'hFFFF_0003);
      load = 1'b1;
      cycle();
      load = 1'b0;
      repeat (4) cycle();
      check("ign_empty", 64'(sb.size()), 64'(0));

      // Back-to-back: second load in the done cycle
      set_in(32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
      load = 1'b1;
      cycle();
      load = 1'b0;
      repeat (4) cycle();
      check("b2b_done", 64'(done), 64'(1));
      set_in(32'hB000_0010, 32'hB000_0011, 32'hB000_0012, 32'hB000_0013);
      load = 1'b1;
      cycle();
      load = 1'b0;
      repeat (5) cycle();
      check("b2b_empty", 64'(sb.size()), 64'(0));

      // Reset mid-group after beat 2 transfers
      set_in(32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003);
      load = 1'b1;
      cycle();
      load = 1'b0;
      repeat (3) cycle();
      reset_n = 1'b0;
      #1;
      check("mid_busy", 64'(busy), 64'(0));
      check("mid_valid", 64'(out_valid), 64'(0));
      check("mid_data", 64'(out_data), 64'(0));
      check("mid_idx", 64'(out_idx), 64'(0));
      check("mid_done", 64'(done), 64'(0));
      sb.delete();
      m_send = 1'b0; m_done = 1'b0; m_stall = 1'b0; m_beat = 0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (4) cycle();
      check("post_rst_empty", 64'(sb.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regs_unloader.md
# regs_unloader

Read-side counterpart of the four-entry complex sample register bank in the FFT datapath. On a single `load` pulse, the block snapshots four packed complex samples (real/imag, `2*bits` wide each) in parallel. It then streams them out one per beat over a valid/ready handshake, so the downstream butterfly or output stage can drain a 4-point group serially. It signals when the group has been fully delivered.

## Interface
- `fix_bit`, default 7: fractional bit position of each real/imag half; carried through for datapath consistency, no arithmetic applied.
- `bits`, default 16: width of each real/imag half; one sample is `2*bits` wide.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `load` in 1: capture request for `in0`..`in3`.
- `in0`..`in3` in `2*bits` each: parallel samples, sampled only on an accepted load.
- `busy` out 1: high while a captured group is not fully delivered.
- `out_data` out `2*bits`: current sample.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts the current beat.
- `out_idx` out 2: source register index (0..3) of the current beat.
- `done` out 1: one-cycle pulse after the last beat transfers.

## Operation
- Reset value of every output is 0: `busy`, `out_data`, `out_valid`, `out_idx` and `done`. The internal snapshot registers, beat counter and state are also cleared.
- The state machine has two states:
  - IDLE: `out_valid`=0 and `busy`=0.
  - SEND: `busy`=1 and `out_valid`=1.
- IDLE -> SEND on `load`=1:
  - Snapshot `in0`..`in3` into internal registers.
  - Clear the beat counter to 0.
- SEND: a beat transfers in any cycle with `out_valid`&&`out_ready`. Each transfer increments the beat counter.
- SEND -> IDLE on the transfer of beat 3. `done`=1 for exactly the following cycle.
- `out_data` = snapshot[`out_idx`]. The default order of `out_idx` is 0,1,2,3.
- `load` is ignored in SEND: no re-snapshot, no counter change. The in-flight group is never corrupted.
- `load` in the cycle where `done`=1 (state is IDLE) is accepted normally. This gives back-to-back groups with one idle cycle between them.
- Changes to `in0`..`in3` after the load edge have no effect on the group in flight.
- `out_ready` may be asserted while `out_valid`=0. It has no effect then.

## Timing
- Load latency: `load` sampled high at edge N gives `out_valid`=1 with beat 0 after edge N. This is a registered output, with no combinational path from `load` or `in*`.
- Minimum group time: with `out_ready` held at 1, there are 4 cycles of `out_valid` after the load edge. `done` is high in the 5th cycle.
- Stall rule: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_idx` hold stable. `out_valid` never drops until the beat transfers.
- `out_ready` is used combinationally only to advance the counter on the next edge. There is no combinational path from `out_ready` to `out_valid`, `out_data` or `out_idx`.
- Reset mid-group: asserting `reset_n`=0 at any time immediately clears all outputs. The partial group is discarded. After release, the block is in IDLE and awaits a new `load`.
- Reset release is synchronised by the implementation's flop behaviour only. The `load` in the first cycle after release is honoured.

## Configuration
- `REGS_UNLOADER_BITREV_EN`:
  - Defined: beats are emitted in 2-bit bit-reversed order, `out_idx` = 0,2,1,3. This matches FFT output reordering. Beat count and timing are unchanged, and `done` still follows the 4th transfer.
  - Undefined: natural order 0,1,2,3.

## Test plan
- Reset then plain drain:
  - Stimulus: release `reset_n`; load `in0..in3` = 0x00010002, 0x00030004, 0x00050006, 0x00070008; hold `out_ready`=1.
  - Required response: `out_data` shows those four values on consecutive cycles with `out_idx` 0..3; `done`=1 one cycle after the last; `busy` falls with it.
- Backpressure:
  - Stimulus: same load, with `out_ready` toggling 1,0,0,1,0,1,1.
  - Required response: each value is held stable during stalls; exactly 4 transfers occur, in order; no value is duplicated or skipped.
- Load during SEND:
  - Stimulus: pulse `load` with new inputs 0xFFFF0000.. at beat 1.
  - Required response: the original group completes unchanged; the new values never appear.
- Back-to-back groups:
  - Stimulus: assert `load` in the `done` cycle with new values.
  - Required response: the second group begins `out_valid` on the next cycle; both groups are delivered intact.
- Reset mid-group:
  - Stimulus: drive `reset_n`=0 after beat 2 transfers.
  - Required response: all outputs read 0 immediately; after release with no `load`, `out_valid` stays 0.
- With `REGS_UNLOADER_BITREV_EN` defined:
  - Stimulus: repeat the plain drain.
  - Required response: order is 0x00010002, 0x00050006, 0x00030004, 0x00070008 with `out_idx` 0,2,1,3.
